sdram_port_arbiter: RTL
=======================

# sdram_port_arbiter

Two-requester arbiter and sequencer for the single command port of `SDRAM_Controller_v`. It lets the sample logger (write stream) and the UART readback/dump engine (read stream) share the SDRAM without coordinating with each other. It runs on the 100 MHz `clk100` domain between the requesters and the controller's `cmd_*`/`data_out*` ports.

## Interface
- `ADDR_W`, 23, SDRAM word address width (matches `cmd_address`).
- `DATA_W`, 32, data width (matches `cmd_data_in`/`data_out`).
- `RD_TIMEOUT`, 255, maximum cycles from read acceptance to `mem_rvalid` before abort.
- `clk`  in  1  system clock (`clk100`).
- `rst`  in  1  asynchronous, active-high reset.
- `rN_req`  in  1  request level, N=0,1; held until `rN_grant`.
- `rN_wr`  in  1  1=write, 0=read; stable while `rN_req`=1.
- `rN_addr`  in  ADDR_W  word address.
- `rN_wdata`  in  DATA_W  write data.
- `rN_grant`  out  1  one-cycle pulse: command accepted by controller.
- `rN_rdata`  out  DATA_W  read data, held until next read completion for N.
- `rN_rvalid`  out  1  one-cycle pulse: `rN_rdata` valid.
- `mem_ready`  in  1  ← `cmd_ready`.
- `mem_enable`  out  1  → `cmd_enable`.
- `mem_wr`  out  1  → `cmd_wr`.
- `mem_addr`  out  ADDR_W  → `cmd_address`.
- `mem_wdata`  out  DATA_W  → `cmd_data_in`.
- `mem_rdata`  in  DATA_W  ← `data_out`.
- `mem_rvalid`  in  1  ← `data_out_ready`.
- `busy`  out  1  state ≠ IDLE.
- `rd_timeout_err`  out  1  sticky; set on read timeout, cleared only by `rst`.

## Operation
- FSM states: IDLE, ISSUE, GRANT, WAIT_READ.
- IDLE: if any `rN_req`, pick winner, latch its wr/addr/wdata into output registers, go to ISSUE. Requests are sampled only in IDLE.
- Arbitration: round-robin over a 1-bit priority pointer `prio`.
  - Both requesting: winner = `prio`.
  - One requesting: that one wins.
  - After each grant, `prio` ← the other requester. Reset `prio`=0.
- ISSUE: `mem_enable`=1 with latched fields. Acceptance = rising edge where `mem_enable`&`mem_ready`.
  - On acceptance, a write goes to GRANT.
  - On acceptance, a read goes to WAIT_READ and clears the timeout counter.
  - `mem_enable` stays high until accepted, with no limit.
- GRANT (writes): `rW_grant`=1 for this one cycle, `mem_enable`=0, requests ignored, then IDLE.
- WAIT_READ:
  - `rW_grant`=1 on the first WAIT_READ cycle only; requests ignored throughout.
  - On `mem_rvalid`=1: capture `mem_rdata` into `rW_rdata`, pulse `rW_rvalid` next cycle, go to IDLE.
  - If the counter reaches `RD_TIMEOUT` first: set `rd_timeout_err`, load `rW_rdata`=32'hDEAD_BEEF, pulse `rW_rvalid`, go to IDLE.
- `mem_rvalid` outside WAIT_READ is ignored.
- `rW_rdata` for the non-winner is untouched.
- Requester obligation: deassert or change `rN_req` on the cycle after it samples `rN_grant`=1. GRANT/WAIT_READ ignore requests, so a duplicate issue cannot occur.
- Reset mid-operation: all state cleared immediately, including an in-flight read, whose response is dropped. `SDRAM_Controller_v` shares the same reset.

## Timing
- Reset values: `mem_enable`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `rN_grant`=0, `rN_rvalid`=0, `rN_rdata`=0, `busy`=0, `rd_timeout_err`=0, state=IDLE, `prio`=0.
- All outputs are registered.
- Request seen in IDLE at edge T: `mem_enable`=1 from T+1.
- Write with `mem_ready`=1 at T+1: accepted at edge T+2, grant high T+2..T+3, IDLE at T+3.
- Minimum write spacing: 3 cycles per command.
- Read: `rN_rvalid` asserts the cycle after `mem_rvalid`.
- Timeout counter width is ⌈log2(RD_TIMEOUT+1)⌉ and saturates. Timeout fires exactly RD_TIMEOUT cycles after acceptance.

## Structure
- Package `sdram_arb_pkg` holds:
  - state encodings (localparams IDLE=0, ISSUE=1, GRANT=2, WAIT_READ=3);
  - `ADDR_W`/`DATA_W` defaults;
  - `RD_ABORT_DATA`=32'hDEAD_BEEF.
- One natural sub-module, `rr_pick2`: registered round-robin pointer plus combinational winner select from (`r0_req`, `r1_req`, `prio`), with an update strobe on grant.
- FSM, latches and timeout counter stay in the top.

## Test plan
- Single write: r0 write addr 0x000010, data 0x12345678, `mem_ready`=1 → `mem_enable` one cycle with those fields; `r0_grant` pulse 1 cycle; `busy` back to 0 after 3 cycles.
- Contention: r0 and r1 both write continuously from reset → grants alternate r0,r1,r0,r1. `mem_addr` alternates accordingly, with no duplicate commands.
- Read routing: r1 reads addr 0x7FFFFF; model returns 0xCAFEF00D 6 cycles later → `r1_rvalid` 1 cycle, `r1_rdata`=0xCAFEF00D, `r0_rdata` unchanged.
- Backpressure: hold `mem_ready`=0 for 20 cycles during ISSUE → `mem_enable` and fields stable all 20 cycles; grant only after `mem_ready` rises.
- Timeout: read accepted, `mem_rvalid` never asserted, RD_TIMEOUT=255 → `rd_timeout_err`=1 at cycle 255, `rN_rdata`=0xDEADBEEF, FSM returns to IDLE and serves the next request.
- Reset mid-read: assert `rst` in WAIT_READ → all outputs reset values asynchronously; a late `mem_rvalid` after release produces no `rN_rvalid`.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// sdram_arb_pkg : shared constants, state encoding and arbitration helper for
//                 the two-port SDRAM command arbiter.
// Revision      : 1.0
// ============================================================================
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 23;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] RD_ABORT_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] GRANT     = 2'd2;
    localparam logic [1:0] WAIT_READ = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = IDLE,
        ST_ISSUE     = ISSUE,
        ST_GRANT     = GRANT,
        ST_WAIT_READ = WAIT_READ
    } arb_state_e;

    // A lone requester always wins; the pointer only breaks ties.
    function automatic logic rr_winner(input logic req0, input logic req1, input logic prio);
        return (req0 && req1) ? prio : req1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 : two-way round-robin picker with a registered priority pointer.
// Revision : 1.0
// ============================================================================
module rr_pick2
    import sdram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic update_i,
    input  logic granted_i,
    output logic winner_o,
    output logic any_o
);

    logic prio_q;

    // The requester just served drops to lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (update_i) begin
            prio_q <= ~granted_i;
        end
    end

    assign winner_o = rr_winner(req0_i, req1_i, prio_q);
    assign any_o    = req0_i | req1_i;

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_port_arbiter : shares one SDRAM controller command port between a
//                      write requester and a read requester, with read timeout.
// Revision           : 1.0
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_grant,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,

    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_grant,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,

    input  logic              mem_ready,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,

    output logic              busy,
    output logic              rd_timeout_err
);

    localparam int                CNT_W      = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO_VAL    = CNT_W'(RD_TIMEOUT);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(RD_ABORT_DATA);

    arb_state_e        state_q;
    logic              owner_q;
    logic              mem_enable_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        grant_q;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] r0_rdata_q;
    logic [DATA_W-1:0] r1_rdata_q;
    logic              busy_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              pick;
    logic              any_req;
    logic              accept;

    assign accept = (state_q == ST_ISSUE) && mem_ready;
    assign cnt_d  = (cnt_q == TMO_VAL) ? cnt_q : cnt_q + 1'b1;

    rr_pick2 u_rr_pick2 (
        .clk       (clk),
        .rst       (rst),
        .req0_i    (r0_req),
        .req1_i    (r1_req),
        .update_i  (accept),
        .granted_i (owner_q),
        .winner_o  (pick),
        .any_o     (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            grant_q      <= 2'b00;
            rvalid_q     <= 2'b00;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            grant_q  <= 2'b00;
            rvalid_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_q      <= pick;
                        mem_enable_q <= 1'b1;
                        mem_wr_q     <= pick ? r1_wr    : r0_wr;
                        mem_addr_q   <= pick ? r1_addr  : r0_addr;
                        mem_wdata_q  <= pick ? r1_wdata : r0_wdata;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        mem_enable_q     <= 1'b0;
                        grant_q[owner_q] <= 1'b1;
                        if (mem_wr_q) begin
                            state_q <= ST_GRANT;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_READ;
                        end
                    end
                end
                ST_GRANT: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_WAIT_READ: begin
                    cnt_q <= cnt_d;
                    // A response arriving on the timeout cycle still wins.
                    if (mem_rvalid) begin
                        if (owner_q) r1_rdata_q <= mem_rdata;
                        else         r0_rdata_q <= mem_rdata;
                        rvalid_q[owner_q] <= 1'b1;
                        busy_q            <= 1'b0;
                        state_q           <= ST_IDLE;
                    end else if (cnt_d == TMO_VAL) begin
                        if (owner_q) r1_rdata_q <= ABORT_DATA;
                        else         r0_rdata_q <= ABORT_DATA;
                        rvalid_q[owner_q] <= 1'b1;
                        err_q             <= 1'b1;
                        busy_q            <= 1'b0;
                        state_q           <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_enable     = mem_enable_q;
    assign mem_wr         = mem_wr_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign r0_grant       = grant_q[0];
    assign r1_grant       = grant_q[1];
    assign r0_rvalid      = rvalid_q[0];
    assign r1_rvalid      = rvalid_q[1];
    assign r0_rdata       = r0_rdata_q;
    assign r1_rdata       = r1_rdata_q;
    assign busy           = busy_q;
    assign rd_timeout_err = err_q;

endmodule
`default_nettype wire
